// File: rtl/trg_pkg.sv
// Shared definitions for the trigger request generator.
//   trgStateT   : one-hot FSM state encoding (Idle, Out, Hold, WaitLow)
//   NchDefault  : default number of discriminator hit channels
//   CtrwDefault : default width of the request/veto counters
//   MajW        : width of the Majority threshold input
package trg_pkg;

    localparam int unsigned NchDefault  = 12;
    localparam int unsigned CtrwDefault = 16;
    localparam int unsigned MajW        = 4;

    typedef enum logic [3:0] {
        StIdle    = 4'b0001,
        StOut     = 4'b0010,
        StHold    = 4'b0100,
        StWaitLow = 4'b1000
    } trgStateT;

endpackage

// File: rtl/trg_hit_sync.sv
// Two-flop synchronizer for the asynchronous discriminator levels.
//   Clock   : system clock
//   Reset   : synchronous, active-low reset (clears both flop stages)
//   HitIn   : asynchronous hit levels, one per channel
//   HitSync : synchronized hit levels (second flop stage)
module trg_hit_sync #(
    parameter int unsigned NCH = 12
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [NCH-1:0] HitIn,
    output logic [NCH-1:0] HitSync
);

    logic [NCH-1:0] stage1Q;
    logic [NCH-1:0] stage2Q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            stage1Q <= '0;
            stage2Q <= '0;
        end else begin
            stage1Q <= HitIn;
            stage2Q <= stage1Q;
        end
    end

    assign HitSync = stage2Q;

endmodule

// File: rtl/trg_req_gen.sv
// Fast-OR trigger request generator. Synchronizes and masks the channel hits,
// applies a majority threshold and emits one fixed-length request pulse per
// rising edge of the qualified condition, followed by a holdoff and a wait for
// the condition to drop.
//   Clock     : system clock
//   Reset     : synchronous, active-low reset
//   HitIn     : asynchronous discriminator levels
//   ChMask    : per-channel enable (1 = enabled)
//   Majority  : minimum simultaneous masked hits (0 acts as 1)
//   PlsLen    : request pulse length in clocks (0 acts as 1)
//   Holdoff   : dead clocks after the pulse ends
//   Enable    : generator armed
//   Busy      : downstream inhibit, vetoes new requests
//   ClrCount  : synchronous clear of both counters
//   TReqOut   : trigger request pulse
//   ReqCount  : saturating count of emitted requests
//   VetoCount : saturating count of Busy-vetoed events
module trg_req_gen
    import trg_pkg::*;
#(
    parameter int unsigned NCH  = NchDefault,
    parameter int unsigned CTRW = CtrwDefault
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [NCH-1:0]  HitIn,
    input  logic [NCH-1:0]  ChMask,
    input  logic [MajW-1:0] Majority,
    input  logic [7:0]      PlsLen,
    input  logic [7:0]      Holdoff,
    input  logic            Enable,
    input  logic            Busy,
    input  logic            ClrCount,
    output logic            TReqOut,
    output logic [CTRW-1:0] ReqCount,
    output logic [CTRW-1:0] VetoCount
);

    logic [NCH-1:0] hitSync;
    logic [NCH-1:0] hm;
    int unsigned    hitCnt;
    int unsigned    majEff;
    logic           cond;
    logic           condQ;
    logic           condDlyQ;
    logic           fire;
    logic [7:0]     plsEff;

    trgStateT       stateQ, stateD;
    logic [7:0]     cntQ, cntD;
    logic           treqQ, treqD;
    logic           reqInc;
    logic           vetoInc;

    trg_hit_sync #(
        .NCH (NCH)
    ) u_sync (
        .Clock   (Clock),
        .Reset   (Reset),
        .HitIn   (HitIn),
        .HitSync (hitSync)
    );

    assign hm = hitSync & ChMask;

    always_comb begin
        hitCnt = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            hitCnt = hitCnt + {31'b0, hm[i]};
        end
        majEff = (Majority == '0) ? 1 : {28'b0, Majority};
        cond   = (hitCnt >= majEff);
    end

    // Condition is registered, and fire is the edge of the registered copy, so the
    // decision is made one clock after synchronization (fixed 4-edge latency).
    assign fire   = condQ & ~condDlyQ;
    assign plsEff = (PlsLen == 8'd0) ? 8'd1 : PlsLen;

    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        treqD   = treqQ;
        reqInc  = 1'b0;
        vetoInc = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (fire && Enable) begin
                    if (Busy) begin
                        vetoInc = 1'b1;
                    end else begin
                        treqD  = 1'b1;
                        cntD   = plsEff - 8'd1;
                        stateD = StOut;
                        reqInc = 1'b1;
                    end
                end
            end
            StOut: begin
                if (cntQ == 8'd0) begin
                    treqD = 1'b0;
                    if (Holdoff != 8'd0) begin
                        stateD = StHold;
                        cntD   = Holdoff - 8'd1;
                    end else begin
                        // Skip the wait state when the condition is already low so
                        // back-to-back spacing stays at pulse + holdoff + 1.
                        stateD = condQ ? StWaitLow : StIdle;
                    end
                end else begin
                    cntD = cntQ - 8'd1;
                end
            end
            StHold: begin
                if (cntQ == 8'd0) begin
                    stateD = condQ ? StWaitLow : StIdle;
                end else begin
                    cntD = cntQ - 8'd1;
                end
            end
            StWaitLow: begin
                if (!condQ) begin
                    stateD = StIdle;
                end
            end
            default: begin
                stateD = StIdle;
                treqD  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            stateQ   <= StIdle;
            cntQ     <= 8'd0;
            treqQ    <= 1'b0;
            condQ    <= 1'b0;
            condDlyQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            treqQ    <= treqD;
            condQ    <= cond;
            condDlyQ <= condQ;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset || ClrCount) begin
            ReqCount  <= '0;
            VetoCount <= '0;
        end else begin
            if (reqInc && (ReqCount != '1)) begin
                ReqCount <= ReqCount + 1'b1;
            end
            if (vetoInc && (VetoCount != '1)) begin
                VetoCount <= VetoCount + 1'b1;
            end
        end
    end

    assign TReqOut = treqQ;

endmodule

// File: tb/tb_trg_req_gen.sv
module tb_trg_req_gen;

    localparam int unsigned NCH  = 12;
    localparam int unsigned CTRW = 4;

    logic            Clock;
    logic            Reset;
    logic [NCH-1:0]  HitIn;
    logic [NCH-1:0]  ChMask;
    logic [3:0]      Majority;
    logic [7:0]      PlsLen;
    logic [7:0]      Holdoff;
    logic            Enable;
    logic            Busy;
    logic            ClrCount;
    logic            TReqOut;
    logic [CTRW-1:0] ReqCount;
    logic [CTRW-1:0] VetoCount;

    int checks;
    int failures;

    trg_req_gen #(
        .NCH  (NCH),
        .CTRW (CTRW)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .HitIn     (HitIn),
        .ChMask    (ChMask),
        .Majority  (Majority),
        .PlsLen    (PlsLen),
        .Holdoff   (Holdoff),
        .Enable    (Enable),
        .Busy      (Busy),
        .ClrCount  (ClrCount),
        .TReqOut   (TReqOut),
        .ReqCount  (ReqCount),
        .VetoCount (VetoCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        HitIn = 12'hFFF;
        for (int t = 1; t <= 3; t++) tick();
        checks++;
        if (TReqOut !== 1'b0) begin
            $display("FAIL reset_treq got=%b want=0", TReqOut);
            failures++;
        end
        checks++;
        if (ReqCount !== 4'd0 || VetoCount !== 4'd0) begin
            $display("FAIL reset_counts got=%0d/%0d want=0/0", ReqCount, VetoCount);
            failures++;
        end
        HitIn = '0;
        Reset = 1'b1;
        for (int t = 1; t <= 5; t++) tick();
    endtask

    task automatic test_basic();
        logic exp;
        Majority = 4'd1; PlsLen = 8'd3; Holdoff = 8'd2; Enable = 1'b1;
        HitIn = 12'h001;
        for (int t = 1; t <= 30; t++) begin
            tick();
            exp = (t >= 4 && t <= 6);
            checks++;
            if (TReqOut !== exp) begin
                $display("FAIL basic_pulse t=%0d got=%b want=%b", t, TReqOut, exp);
                failures++;
            end
            if (t == 10) HitIn = '0;
        end
        checks++;
        if (ReqCount !== 4'd1) begin
            $display("FAIL basic_reqcount got=%0d want=1", ReqCount);
            failures++;
        end
    endtask

    task automatic test_majority();
        logic exp;
        Majority = 4'd2;
        for (int pass = 0; pass < 2; pass++) begin
            ChMask = (pass == 0) ? 12'hFFF : 12'hF7F;
            HitIn  = 12'h008;
            for (int t = 1; t <= 20; t++) begin
                tick();
                exp = (pass == 0) && (t >= 7 && t <= 9);
                checks++;
                if (TReqOut !== exp) begin
                    $display("FAIL majority_pass%0d t=%0d got=%b want=%b", pass, t, TReqOut, exp);
                    failures++;
                end
                if (t == 3) HitIn = 12'h088;
                if (t == 4) HitIn = '0;
            end
            checks++;
            if (ReqCount !== 4'd2) begin
                $display("FAIL majority_reqcount pass%0d got=%0d want=2", pass, ReqCount);
                failures++;
            end
        end
        ChMask = 12'hFFF;
    endtask

    task automatic test_back_to_back();
        logic exp;
        Majority = 4'd0; PlsLen = 8'd0; Holdoff = 8'd0;
        HitIn = 12'h002;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp = (t == 4 || t == 6);
            checks++;
            if (TReqOut !== exp) begin
                $display("FAIL b2b_pulse t=%0d got=%b want=%b", t, TReqOut, exp);
                failures++;
            end
            if (t == 1) HitIn = '0;
            if (t == 2) HitIn = 12'h002;
            if (t == 3) HitIn = '0;
        end
        checks++;
        if (ReqCount !== 4'd4) begin
            $display("FAIL b2b_reqcount got=%0d want=4", ReqCount);
            failures++;
        end
        Majority = 4'd1; PlsLen = 8'd3; Holdoff = 8'd2;
    endtask

    task automatic test_busy();
        logic exp;
        Busy  = 1'b1;
        HitIn = 12'h004;
        for (int t = 1; t <= 15; t++) begin
            tick();
            checks++;
            if (TReqOut !== 1'b0) begin
                $display("FAIL busy_veto t=%0d got=%b want=0", t, TReqOut);
                failures++;
            end
            if (t == 3) HitIn = '0;
        end
        checks++;
        if (VetoCount !== 4'd1 || ReqCount !== 4'd4) begin
            $display("FAIL busy_counts got=%0d/%0d want=4/1", ReqCount, VetoCount);
            failures++;
        end
        Busy  = 1'b0;
        HitIn = 12'h004;
        for (int t = 1; t <= 15; t++) begin
            tick();
            exp = (t >= 4 && t <= 6);
            checks++;
            if (TReqOut !== exp) begin
                $display("FAIL busy_mid_pulse t=%0d got=%b want=%b", t, TReqOut, exp);
                failures++;
            end
            if (t == 3) HitIn = '0;
            if (t == 4) Busy = 1'b1;
        end
        Busy = 1'b0;
        checks++;
        if (VetoCount !== 4'd1 || ReqCount !== 4'd5) begin
            $display("FAIL busy_mid_counts got=%0d/%0d want=5/1", ReqCount, VetoCount);
            failures++;
        end
    endtask

    task automatic test_continuous();
        logic exp;
        HitIn = 12'h001;
        for (int t = 1; t <= 60; t++) begin
            tick();
            exp = (t >= 4 && t <= 6);
            checks++;
            if (TReqOut !== exp) begin
                $display("FAIL cont_hold t=%0d got=%b want=%b", t, TReqOut, exp);
                failures++;
            end
            if (t == 50) HitIn = '0;
        end
        HitIn = 12'h001;
        for (int t = 1; t <= 15; t++) begin
            tick();
            exp = (t >= 4 && t <= 6);
            checks++;
            if (TReqOut !== exp) begin
                $display("FAIL cont_rearm t=%0d got=%b want=%b", t, TReqOut, exp);
                failures++;
            end
            if (t == 3) HitIn = '0;
        end
        checks++;
        if (ReqCount !== 4'd7) begin
            $display("FAIL cont_reqcount got=%0d want=7", ReqCount);
            failures++;
        end
    endtask

    task automatic test_enable();
        Enable = 1'b0;
        HitIn  = 12'h001;
        for (int t = 1; t <= 15; t++) begin
            tick();
            checks++;
            if (TReqOut !== 1'b0) begin
                $display("FAIL enable_off t=%0d got=%b want=0", t, TReqOut);
                failures++;
            end
            if (t == 3) HitIn = '0;
        end
        checks++;
        if (ReqCount !== 4'd7 || VetoCount !== 4'd1) begin
            $display("FAIL enable_counts got=%0d/%0d want=7/1", ReqCount, VetoCount);
            failures++;
        end
        Enable = 1'b1;
    endtask

    task automatic test_clear();
        logic exp;
        HitIn = 12'h001;
        for (int t = 1; t <= 15; t++) begin
            tick();
            exp = (t >= 4 && t <= 6);
            checks++;
            if (TReqOut !== exp) begin
                $display("FAIL clear_pulse t=%0d got=%b want=%b", t, TReqOut, exp);
                failures++;
            end
            if (t == 4) begin
                checks++;
                if (ReqCount !== 4'd0 || VetoCount !== 4'd0) begin
                    $display("FAIL clear_wins got=%0d/%0d want=0/0", ReqCount, VetoCount);
                    failures++;
                end
                ClrCount = 1'b0;
            end
            if (t == 3) begin
                HitIn    = '0;
                ClrCount = 1'b1;
            end
        end
    endtask

    task automatic send_hit();
        HitIn = 12'h001;
        tick();
        tick();
        HitIn = '0;
        for (int t = 1; t <= 12; t++) tick();
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 15; n++) send_hit();
        checks++;
        if (ReqCount !== 4'd15) begin
            $display("FAIL sat_reach got=%0d want=15", ReqCount);
            failures++;
        end
        send_hit();
        checks++;
        if (ReqCount !== 4'd15) begin
            $display("FAIL sat_hold got=%0d want=15", ReqCount);
            failures++;
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic exp;
        HitIn = 12'h001;
        for (int t = 1; t <= 4; t++) tick();
        checks++;
        if (TReqOut !== 1'b1) begin
            $display("FAIL rst_mid_pre got=%b want=1", TReqOut);
            failures++;
        end
        Reset = 1'b0;
        HitIn = '0;
        tick();
        checks++;
        if (TReqOut !== 1'b0 || ReqCount !== 4'd0) begin
            $display("FAIL rst_mid_edge got=%b/%0d want=0/0", TReqOut, ReqCount);
            failures++;
        end
        Reset = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            checks++;
            if (TReqOut !== 1'b0) begin
                $display("FAIL rst_mid_quiet t=%0d got=%b want=0", t, TReqOut);
                failures++;
            end
        end
        HitIn = 12'h001;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp = (t >= 4 && t <= 6);
            checks++;
            if (TReqOut !== exp) begin
                $display("FAIL rst_mid_recover t=%0d got=%b want=%b", t, TReqOut, exp);
                failures++;
            end
            if (t == 3) HitIn = '0;
        end
        checks++;
        if (ReqCount !== 4'd1) begin
            $display("FAIL rst_mid_reqcount got=%0d want=1", ReqCount);
            failures++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b0;
        HitIn    = '0;
        ChMask   = 12'hFFF;
        Majority = 4'd1;
        PlsLen   = 8'd3;
        Holdoff  = 8'd2;
        Enable   = 1'b1;
        Busy     = 1'b0;
        ClrCount = 1'b0;
        test_reset();
        test_basic();
        test_majority();
        test_back_to_back();
        test_busy();
        test_continuous();
        test_enable();
        test_clear();
        test_saturation();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trg_req_gen.md
Name: trg_req_gen

Overview:
- Front-end-board transmitter of the fast-OR trigger request sent to the event builder, where it is stretched, delayed and put in coincidence.
- Synchronizes per-channel discriminator hits, masks them, applies a programmable majority requirement and emits one clean, fixed-length request pulse per qualifying event.
- Enforces holdoff and re-arm rules so that long hits never produce multiple or runt requests.
- Keeps saturating counters of requests sent and requests vetoed.

Parameters:
NCH, 12, number of discriminator hit inputs
CTRW, 16, width of the request and veto counters

Ports:
Clock  input  1  system clock
Reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge Clock)
HitIn  input  NCH  asynchronous discriminator levels, one per channel
ChMask  input  NCH  1 = channel enabled
Majority  input  4  minimum number of simultaneous masked hits; 0 is treated as 1
PlsLen  input  8  request pulse length in clocks; 0 is treated as 1
Holdoff  input  8  dead clocks after the pulse ends
Enable  input  1  1 = generator armed
Busy  input  1  inhibit from downstream; vetoes new requests
ClrCount  input  1  synchronous clear of both counters
TReqOut  output  1  trigger request to event builder
ReqCount  output  CTRW  requests emitted, saturating
VetoCount  output  CTRW  qualifying events vetoed by Busy, saturating

Behaviour:
- Reset (Reset==0 at posedge): TReqOut=0, ReqCount=0, VetoCount=0, state=IDLE, synchronizer flops=0, Cond_d=0.
- Synchronizer: each HitIn bit passes through two flops (S2). Hm = S2 & ChMask.
- Cond = popcount(Hm) >= max(Majority,1). Cond is registered as Cond_d.
- Fire = Cond & ~Cond_d (rising edge of the condition only).
- States (one-hot):
  - IDLE: if Fire & Enable & ~Busy, then TReqOut<=1, load counter with max(PlsLen,1)-1, go to OUT, ReqCount++. If Fire & Enable & Busy, then VetoCount++ and stay in IDLE. If Enable==0, Fire is ignored and not counted.
  - OUT: TReqOut held at 1. The counter decrements; at 0, TReqOut<=0. Then go to HOLD, loading Holdoff, if Holdoff!=0; otherwise go to WAITLOW.
  - HOLD: the counter decrements; at 0, go to WAITLOW.
  - WAITLOW: go to IDLE when Cond==0; otherwise stay. No Fire is possible until the condition has dropped.
- Latency: HitIn edge to TReqOut rise is exactly 4 Clock edges (2 sync + Cond_d/Fire evaluation + output register).
- Pulse width: exactly max(PlsLen,1) clocks.
- Minimum spacing between request rising edges: max(PlsLen,1) + Holdoff + 1 clocks.
- Enable or Busy changing during OUT or HOLD does not truncate or extend the pulse. No runt pulses are allowed.
- Counters saturate at 2^CTRW-1.
- ClrCount and an increment in the same cycle: the clear wins and the counter is 0.
- Reset asserted mid-pulse: TReqOut=0 at that edge, all state returns to IDLE.
- Fire is evaluated only in IDLE. Events occurring in OUT, HOLD or WAITLOW are neither sent nor counted.
- Mask changes take effect combinationally on Hm. A mask change that raises Cond in IDLE is a legitimate Fire.

Decomposition:
- Shared package trg_pkg: one-hot state constants (IDLE, OUT, HOLD, WAITLOW); default widths for NCH and CTRW; the Majority width of 4.
- Sub-module trg_hit_sync: NCH-wide 2-flop synchronizer with the active-low synchronous reset.
- Popcount and the FSM stay in trg_req_gen.

Test Plan:
- Reset deassert; Majority=1, PlsLen=3, Holdoff=2, Enable=1; HitIn[0] pulse 10 clocks wide -> TReqOut high for exactly 3 clocks, starting 4 edges after the hit; ReqCount=1; no second pulse.
- Majority=2; HitIn[3] alone, then HitIn[3]+HitIn[7] overlapping by 1 clock -> a single request only on the overlap; with ChMask[7]=0 -> no request.
- PlsLen=0, Holdoff=0; two 1-clock hits spaced 2 clocks apart (after sync) -> two 1-clock pulses, 2 clocks apart; ReqCount=2.
- Busy=1 during a qualifying hit -> TReqOut stays 0, VetoCount=1. Busy rising during OUT -> pulse completes its full length.
- Continuous hit held for 50 clocks -> exactly one request; a new request is possible only after the hit drops and rises again.
- ReqCount preset near saturation via 65535 hits (or CTRW=4 with 15 hits): the next hit -> count holds at max. ClrCount asserted in the same cycle as a Fire -> count=0 and the pulse is still emitted. Reset=0 mid-pulse -> TReqOut=0 at that edge.
